// File: rtl/sha_mem_pkg.sv
// Shared types and widths for the SHA core memory arbiter.
// The word memory is single-ported with a 1-cycle synchronous read.
package sha_mem_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  typedef logic [ADDR_W-1:0] mem_addr_t;
  typedef logic [DATA_W-1:0] mem_word_t;

  typedef struct packed {
    logic      we;
    mem_addr_t addr;
    mem_word_t wdata;
  } mem_req_t;

  // Index width for an N-entry one-hot, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sha_mem_arbiter_if.sv
// Requester-side bus of the arbiter: per-requester request fields in,
// grant / read-return out. Requester k occupies index [k] of every vector.
interface sha_mem_arbiter_if #(
  parameter int NUM_REQ = 2
);

  logic [NUM_REQ-1:0]                           req_i;
  logic [NUM_REQ-1:0]                           lock_i;
  logic [NUM_REQ-1:0]                           we_i;
  logic [NUM_REQ-1:0][sha_mem_pkg::ADDR_W-1:0]  addr_i;
  logic [NUM_REQ-1:0][sha_mem_pkg::DATA_W-1:0]  wdata_i;
  logic [NUM_REQ-1:0]                           gnt_o;
  logic [NUM_REQ-1:0]                           rvalid_o;
  logic [sha_mem_pkg::DATA_W-1:0]               rdata_o;

  modport master (
    output req_i, lock_i, we_i, addr_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o
  );

  modport slave (
    input  req_i, lock_i, we_i, addr_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o
  );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first set request after index last_i,
// wrapping modulo N. Returns one-hot grant, its index, and whether any won.
module rr_picker
  import sha_mem_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [IW-1:0] k;
  logic          found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    k     = '0;
    for (int s = 1; s <= N; s++) begin
      k = IW'((int'(last_i) + s) % N);
      if (!found && req_i[k]) begin
        found    = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = k;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/sha_mem_arbiter.sv
// Round-robin arbiter with burst lock sharing one single-port word memory
// among NUM_REQ requesters; read data returns one cycle after the grant.
module sha_mem_arbiter
  import sha_mem_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int MAX_LOCK = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  sha_mem_arbiter_if.slave    bus,
  output logic                memory_clk,
  output logic                enable_write,
  output mem_addr_t           memory_addr,
  output mem_word_t           memory_write_data,
  input  mem_word_t           memory_read_data
);

  localparam int IW = idx_w(NUM_REQ);
  localparam int CW = idx_w(MAX_LOCK);
  localparam logic [CW-1:0] LOCK_LAST = CW'(MAX_LOCK - 1);
  localparam logic [IW-1:0] LAST_RST  = IW'(NUM_REQ - 1);

  logic               busy_q, busy_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [IW-1:0]      last_q, last_d;
  logic [CW-1:0]      lock_cnt_q, lock_cnt_d;
  logic [NUM_REQ-1:0] rd_tag_q, rd_tag_d;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;

  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]      sel_idx;
  logic               active;
  logic               granted;
  mem_req_t           sel_req;

  rr_picker #(.N(NUM_REQ)) u_pick (
    .req_i  (bus.req_i),
    .last_i (last_q),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  always_comb begin
    // A locked owner keeps the port even while idle; its tenure still counts.
    sel_idx = busy_q ? owner_q : pick_idx;
    active  = busy_q | pick_any;

    gnt = '0;
    if (busy_q) gnt[owner_q] = bus.req_i[owner_q];
    else        gnt          = pick_gnt;
    granted = |gnt;

    sel_req.we    = bus.we_i[sel_idx];
    sel_req.addr  = bus.addr_i[sel_idx];
    sel_req.wdata = bus.wdata_i[sel_idx];

    enable_write      = granted & sel_req.we;
    memory_addr       = granted ? sel_req.addr  : '0;
    memory_write_data = granted ? sel_req.wdata : '0;

    busy_d     = busy_q;
    owner_d    = owner_q;
    last_d     = last_q;
    lock_cnt_d = lock_cnt_q;
    rd_tag_d   = gnt & ~bus.we_i;

    if (active) begin
      owner_d = sel_idx;
      if (bus.lock_i[sel_idx] && (lock_cnt_q < LOCK_LAST)) begin
        busy_d     = 1'b1;
        lock_cnt_d = lock_cnt_q + 1'b1;
      end else begin
        // Voluntary or forced release: rotation resumes after this owner.
        busy_d     = 1'b0;
        lock_cnt_d = '0;
        last_d     = sel_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q     <= 1'b0;
      owner_q    <= '0;
      last_q     <= LAST_RST;
      lock_cnt_q <= '0;
      rd_tag_q   <= '0;
    end else begin
      busy_q     <= busy_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      lock_cnt_q <= lock_cnt_d;
      rd_tag_q   <= rd_tag_d;
    end
  end

  assign bus.gnt_o    = gnt;
  assign bus.rvalid_o = rd_tag_q;
  assign bus.rdata_o  = memory_read_data;
  assign memory_clk   = clk;

endmodule

// File: tb/tb_sha_mem_arbiter.sv
// Bench for sha_mem_arbiter: directed vector table, a single-requester read
// stream, and random traffic checked against a tenure-based reference model.
module tb_sha_mem_arbiter;
  localparam int NREQ = 2;
  localparam int MAXL = 4;

  logic        clk;
  logic        rst_n;
  logic        memory_clk;
  logic        enable_write;
  logic [15:0] memory_addr;
  logic [31:0] memory_write_data;
  logic [31:0] memory_read_data;

  sha_mem_arbiter_if #(.NUM_REQ(NREQ)) bus ();

  sha_mem_arbiter #(.NUM_REQ(NREQ), .MAX_LOCK(MAXL)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .bus               (bus),
    .memory_clk        (memory_clk),
    .enable_write      (enable_write),
    .memory_addr       (memory_addr),
    .memory_write_data (memory_write_data),
    .memory_read_data  (memory_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input logic [15:0] a);
    return {a ^ 16'h5A5A, ~a};
  endfunction

  // Memory: 256 words, unwritten words read back init_val(addr).
  bit [31:0] mem_q [0:255];
  bit [255:0] mem_v;
  always @(posedge clk) begin
    memory_read_data <= mem_v[memory_addr[7:0]] ? mem_q[memory_addr[7:0]] : init_val(memory_addr);
    if (enable_write) begin
      mem_q[memory_addr[7:0]] <= memory_write_data;
      mem_v[memory_addr[7:0]] <= 1'b1;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit rst, input logic [1:0] req, input logic [1:0] lock,
                       input logic [1:0] we, input logic [15:0] a0, input logic [15:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1);
    @(negedge clk);
    rst_n       = ~rst;
    bus.req_i   = req;
    bus.lock_i  = lock;
    bus.we_i    = we;
    bus.addr_i  = {a1, a0};
    bus.wdata_i = {d1, d0};
    #2;
  endtask

  typedef struct {
    bit          rst;
    bit          chk;
    logic [1:0]  req, lock, we;
    logic [15:0] a0, a1;
    logic [31:0] d0, d1;
    logic [1:0]  gnt;
    logic        ew;
    logic [15:0] addr;
    logic [31:0] wd;
    logic [1:0]  rv;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit rst, input bit c, input logic [1:0] req, input logic [1:0] lock,
                     input logic [1:0] we, input logic [15:0] a0, input logic [15:0] a1,
                     input logic [31:0] d0, input logic [1:0] gnt, input logic ew,
                     input logic [15:0] addr, input logic [31:0] wd, input logic [1:0] rv,
                     input logic [31:0] rd);
    vec_t v;
    v.rst = rst; v.chk = c; v.req = req; v.lock = lock; v.we = we;
    v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = 32'h0;
    v.gnt = gnt; v.ew = ew; v.addr = addr; v.wd = wd; v.rv = rv; v.rd = rd;
    vecs.push_back(v);
  endtask

  // Reference model state: rotation pointer, current holder, holder tenure.
  int          m_last, m_holder, m_tenure;
  logic [1:0]  m_rv;
  logic [31:0] m_rd;
  logic [31:0] m_mem [int];

  task automatic model_reset();
    m_last = NREQ - 1; m_holder = -1; m_tenure = 0; m_rv = '0; m_rd = '0;
  endtask

  initial begin
    int pulses;
    vec_t v;
    logic [1:0]  r_req, r_lock, r_we;
    logic [1:0][15:0] r_a;
    logic [1:0][31:0] r_d;
    int cand;
    bit issue;
    logic [1:0]  e_gnt;
    logic [15:0] ea;

    rst_n = 1'b0;
    bus.req_i = '0; bus.lock_i = '0; bus.we_i = '0; bus.addr_i = '0; bus.wdata_i = '0;

    // ---- single requester 1, back-to-back reads 0x00..0x0F
    drive(1, 2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 32'h0, 32'h0);
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      drive(0, 2'b10, 2'b00, 2'b00, 16'h0, 16'(i), 32'h0, 32'h0);
      chk($sformatf("burst%0d.gnt", i), bus.gnt_o, 2'b10);
      chk($sformatf("burst%0d.addr", i), memory_addr, 16'(i));
      if (bus.rvalid_o == 2'b10) pulses++;
      if (i > 0) chk($sformatf("burst%0d.rdata", i), bus.rdata_o, init_val(16'(i - 1)));
    end
    drive(0, 2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 32'h0, 32'h0);
    if (bus.rvalid_o == 2'b10) pulses++;
    chk("burst.rdata_last", bus.rdata_o, init_val(16'h0F));
    chk("burst.rvalid_pulses", 64'(pulses), 64'd16);

    // ---- directed table
    // reset state, then alternating reads 0x10 / 0x20
    add(1,0, 2'b00,2'b00,2'b00, 16'h10,16'h20,0, 2'b00,0,16'h0,0, 2'b00,0);
    add(0,1, 2'b00,2'b00,2'b00, 16'h10,16'h20,0, 2'b00,0,16'h0,0, 2'b00,0);
    add(0,1, 2'b11,2'b00,2'b00, 16'h10,16'h20,0, 2'b01,0,16'h10,0, 2'b00,0);
    add(0,1, 2'b11,2'b00,2'b00, 16'h10,16'h20,0, 2'b10,0,16'h20,0, 2'b01,init_val(16'h10));
    add(0,1, 2'b11,2'b00,2'b00, 16'h10,16'h20,0, 2'b01,0,16'h10,0, 2'b10,init_val(16'h20));
    add(0,1, 2'b11,2'b00,2'b00, 16'h10,16'h20,0, 2'b10,0,16'h20,0, 2'b01,init_val(16'h10));
    add(0,1, 2'b00,2'b00,2'b00, 16'h10,16'h20,0, 2'b00,0,16'h0,0, 2'b10,init_val(16'h20));
    add(0,1, 2'b00,2'b00,2'b00, 16'h10,16'h20,0, 2'b00,0,16'h0,0, 2'b00,0);
    // locked write burst by req0, req1 waits until cycle 5
    add(1,0, 2'b00,2'b00,2'b00, 16'h0,16'h0,0, 2'b00,0,16'h0,0, 2'b00,0);
    for (int i = 0; i < 4; i++)
      add(0,1, 2'b11,2'b01,2'b01, 16'h05,16'h20,32'hDEADBEEF, 2'b01,1,16'h05,32'hDEADBEEF, 2'b00,0);
    add(0,1, 2'b10,2'b00,2'b00, 16'h05,16'h20,0, 2'b10,0,16'h20,0, 2'b00,0);
    add(0,1, 2'b01,2'b00,2'b00, 16'h05,16'h20,0, 2'b01,0,16'h05,0, 2'b10,init_val(16'h20));
    add(0,1, 2'b00,2'b00,2'b00, 16'h05,16'h20,0, 2'b00,0,16'h0,0, 2'b01,32'hDEADBEEF);
    // lock held continuously: forced release after MAXL cycles
    add(1,0, 2'b00,2'b00,2'b00, 16'h0,16'h0,0, 2'b00,0,16'h0,0, 2'b00,0);
    add(0,1, 2'b11,2'b01,2'b00, 16'h10,16'h20,0, 2'b01,0,16'h10,0, 2'b00,0);
    for (int i = 0; i < 3; i++)
      add(0,1, 2'b11,2'b01,2'b00, 16'h10,16'h20,0, 2'b01,0,16'h10,0, 2'b01,init_val(16'h10));
    add(0,1, 2'b11,2'b01,2'b00, 16'h10,16'h20,0, 2'b10,0,16'h20,0, 2'b01,init_val(16'h10));
    add(0,1, 2'b11,2'b01,2'b00, 16'h10,16'h20,0, 2'b01,0,16'h10,0, 2'b10,init_val(16'h20));
    add(0,1, 2'b00,2'b00,2'b00, 16'h10,16'h20,0, 2'b00,0,16'h0,0, 2'b01,init_val(16'h10));
    // locked owner idles; req1 waits, then wins after release
    add(1,0, 2'b00,2'b00,2'b00, 16'h0,16'h0,0, 2'b00,0,16'h0,0, 2'b00,0);
    add(0,1, 2'b11,2'b01,2'b00, 16'h30,16'h20,0, 2'b01,0,16'h30,0, 2'b00,0);
    add(0,1, 2'b10,2'b01,2'b01, 16'h30,16'h20,0, 2'b00,0,16'h0,0, 2'b01,init_val(16'h30));
    add(0,1, 2'b10,2'b01,2'b01, 16'h30,16'h20,0, 2'b00,0,16'h0,0, 2'b00,0);
    add(0,1, 2'b10,2'b00,2'b01, 16'h30,16'h20,0, 2'b00,0,16'h0,0, 2'b00,0);
    add(0,1, 2'b10,2'b00,2'b00, 16'h30,16'h20,0, 2'b10,0,16'h20,0, 2'b00,0);
    add(0,1, 2'b00,2'b00,2'b00, 16'h30,16'h20,0, 2'b00,0,16'h0,0, 2'b10,init_val(16'h20));
    // reset in the middle of a locked read burst
    add(1,0, 2'b00,2'b00,2'b00, 16'h0,16'h0,0, 2'b00,0,16'h0,0, 2'b00,0);
    add(0,1, 2'b01,2'b01,2'b00, 16'h40,16'h20,0, 2'b01,0,16'h40,0, 2'b00,0);
    add(0,1, 2'b01,2'b01,2'b00, 16'h40,16'h20,0, 2'b01,0,16'h40,0, 2'b01,init_val(16'h40));
    add(1,0, 2'b11,2'b01,2'b00, 16'h40,16'h20,0, 2'b00,0,16'h0,0, 2'b00,0);
    add(0,1, 2'b10,2'b00,2'b00, 16'h40,16'h20,0, 2'b10,0,16'h20,0, 2'b00,0);
    add(0,1, 2'b11,2'b00,2'b00, 16'h40,16'h20,0, 2'b01,0,16'h40,0, 2'b10,init_val(16'h20));
    add(0,1, 2'b00,2'b00,2'b00, 16'h40,16'h20,0, 2'b00,0,16'h0,0, 2'b01,init_val(16'h40));

    foreach (vecs[i]) begin
      v = vecs[i];
      drive(v.rst, v.req, v.lock, v.we, v.a0, v.a1, v.d0, v.d1);
      if (v.chk) begin
        chk($sformatf("vec%0d.gnt", i), bus.gnt_o, v.gnt);
        chk($sformatf("vec%0d.we", i), enable_write, v.ew);
        chk($sformatf("vec%0d.addr", i), memory_addr, v.addr);
        chk($sformatf("vec%0d.wdata", i), memory_write_data, v.wd);
        chk($sformatf("vec%0d.rvalid", i), bus.rvalid_o, v.rv);
        if (v.rv != 2'b00) chk($sformatf("vec%0d.rdata", i), bus.rdata_o, v.rd);
      end
    end

    // ---- random traffic vs reference model (addresses 0x80..0xBF only)
    drive(1, 2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 32'h0, 32'h0);
    model_reset();
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 63) == 0) begin
        drive(1, 2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 32'h0, 32'h0);
        model_reset();
        continue;
      end
      for (int k = 0; k < NREQ; k++) begin
        r_req[k]  = ($urandom_range(0, 3) != 0);
        r_lock[k] = $urandom_range(0, 1) == 1;
        r_we[k]   = $urandom_range(0, 2) == 0;
        r_a[k]    = 16'h80 + 16'($urandom_range(0, 63));
        r_d[k]    = $urandom;
      end
      drive(0, r_req, r_lock, r_we, r_a[0], r_a[1], r_d[0], r_d[1]);

      cand = -1; issue = 0;
      if (m_holder >= 0) begin
        cand = m_holder; issue = r_req[cand];
      end else begin
        for (int s = 1; s <= NREQ; s++) begin
          if (cand < 0 && r_req[(m_last + s) % NREQ]) begin
            cand = (m_last + s) % NREQ; issue = 1;
          end
        end
      end
      e_gnt = '0;
      if (issue) e_gnt[cand] = 1'b1;
      ea = issue ? r_a[cand] : 16'h0;
      chk($sformatf("rnd%0d.gnt", c), bus.gnt_o, e_gnt);
      chk($sformatf("rnd%0d.we", c), enable_write, issue ? r_we[cand] : 1'b0);
      chk($sformatf("rnd%0d.addr", c), memory_addr, ea);
      chk($sformatf("rnd%0d.wdata", c), memory_write_data, issue ? r_d[cand] : 32'h0);
      chk($sformatf("rnd%0d.rvalid", c), bus.rvalid_o, m_rv);
      if (m_rv != 2'b00) chk($sformatf("rnd%0d.rdata", c), bus.rdata_o, m_rd);

      m_rv = e_gnt & ~r_we;
      if (issue && !r_we[cand]) m_rd = m_mem.exists(int'(ea)) ? m_mem[int'(ea)] : init_val(ea);
      if (issue && r_we[cand]) m_mem[int'(ea)] = r_d[cand];
      // Holder keeps the port while it asks for lock and its tenure is under MAXL.
      if (cand >= 0) begin
        m_tenure++;
        if (r_lock[cand] && m_tenure < MAXL) m_holder = cand;
        else begin
          m_holder = -1; m_tenure = 0; m_last = cand;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
